sb_tx_arbiter: RTL and testbench



---
 rtl/sb_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_sb_tx_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband transmitter between the TX-path requester
// and the RX-path responder. Define SB_ARB_TIMEOUT_EN to enable the GRANT timeout.
module sb_tx_arbiter #(
    parameter int unsigned SB_MSG_WIDTH   = 4
`ifdef SB_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_tx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_tx_msg,
    input  logic                    i_rx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_rx_msg,
    input  logic                    i_sb_busy,
    output logic                    o_sb_valid,
    output logic [SB_MSG_WIDTH-1:0] o_sb_msg,
    output logic                    o_sb_src,
    output logic                    o_tx_done,
    output logic                    o_rx_done,
    output logic                    o_arb_busy,
    output logic                    o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic SRC_RX = 1'b1;

    state_t state;
    logic   last_served;
    logic   mask_tx;
    logic   mask_rx;
    logic   tx_req;
    logic   rx_req;
    logic   winner;
    logic   granted_valid;

`ifdef SB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] grant_cnt;
    logic             timeout_hit;

    assign timeout_hit = (grant_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // The just-served source is masked for one IDLE cycle so a late valid drop cannot regrant it.
    always_comb begin
        tx_req        = i_tx_valid & ~mask_tx;
        rx_req        = i_rx_valid & ~mask_rx;
        winner        = (tx_req & rx_req) ? ~last_served : rx_req;
        granted_valid = o_sb_src ? i_rx_valid : i_tx_valid;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            last_served <= SRC_RX;
            mask_tx     <= 1'b0;
            mask_rx     <= 1'b0;
            o_sb_valid  <= 1'b0;
            o_sb_msg    <= '0;
            o_sb_src    <= 1'b0;
            o_tx_done   <= 1'b0;
            o_rx_done   <= 1'b0;
            o_arb_busy  <= 1'b0;
            o_timeout   <= 1'b0;
`ifdef SB_ARB_TIMEOUT_EN
            grant_cnt   <= '0;
`endif
        end else begin
            o_tx_done <= 1'b0;
            o_rx_done <= 1'b0;
            o_timeout <= 1'b0;
            mask_tx   <= 1'b0;
            mask_rx   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_req | rx_req) begin
                        state      <= ST_GRANT;
                        o_sb_valid <= 1'b1;
                        o_arb_busy <= 1'b1;
                        o_sb_src   <= winner;
                        o_sb_msg   <= winner ? i_rx_msg : i_tx_msg;
`ifdef SB_ARB_TIMEOUT_EN
                        grant_cnt  <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    if (i_sb_busy) begin
                        state      <= ST_SEND;
                        o_sb_valid <= 1'b0;
                    end else if (!granted_valid) begin
                        // Requester withdrew before the encoder accepted.
                        state      <= ST_IDLE;
                        o_sb_valid <= 1'b0;
                        o_arb_busy <= 1'b0;
                    end
`ifdef SB_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state       <= ST_IDLE;
                        o_sb_valid  <= 1'b0;
                        o_arb_busy  <= 1'b0;
                        o_timeout   <= 1'b1;
                        last_served <= o_sb_src;
                    end else begin
                        grant_cnt <= grant_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_SEND: begin
                    if (!i_sb_busy) begin
                        state     <= ST_DONE;
                        o_tx_done <= ~o_sb_src;
                        o_rx_done <= o_sb_src;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    o_arb_busy  <= 1'b0;
                    last_served <= o_sb_src;
                    mask_tx     <= ~o_sb_src;
                    mask_rx     <= o_sb_src;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Bench for sb_tx_arbiter: directed vector table, randomized requesters/encoder against
// a rule-level reference model, and a timeout sequence when SB_ARB_TIMEOUT_EN is defined.
module tb_sb_tx_arbiter;

    logic       clk;
    logic       rst_n;
    logic       tx_valid;
    logic [3:0] tx_msg;
    logic       rx_valid;
    logic [3:0] rx_msg;
    logic       sb_busy;
    logic       o_sb_valid;
    logic [3:0] o_sb_msg;
    logic       o_sb_src;
    logic       o_tx_done;
    logic       o_rx_done;
    logic       o_arb_busy;
    logic       o_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    sb_tx_arbiter #(
        .SB_MSG_WIDTH(4)
`ifdef SB_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tx_valid(tx_valid),
        .i_tx_msg  (tx_msg),
        .i_rx_valid(rx_valid),
        .i_rx_msg  (rx_msg),
        .i_sb_busy (sb_busy),
        .o_sb_valid(o_sb_valid),
        .o_sb_msg  (o_sb_msg),
        .o_sb_src  (o_sb_src),
        .o_tx_done (o_tx_done),
        .o_rx_done (o_rx_done),
        .o_arb_busy(o_arb_busy),
        .o_timeout (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word: {valid, msg[3:0], src, tx_done, rx_done, arb_busy, timeout}
    typedef struct packed {
        logic       rst_n;
        logic       txv;
        logic [3:0] txm;
        logic       rxv;
        logic [3:0] rxm;
        logic       busy;
        logic [9:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic txv, input logic [3:0] txm,
                                input logic rxv, input logic [3:0] rxm, input logic b,
                                input logic ev, input logic [3:0] em, input logic es,
                                input logic etd, input logic erd, input logic eab);
        vec_t v;
        v.rst_n = r;
        v.txv   = txv;
        v.txm   = txm;
        v.rxv   = rxv;
        v.rxm   = rxm;
        v.busy  = b;
        v.exp   = {ev, em, es, etd, erd, eab, 1'b0};
        return v;
    endfunction

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = {o_sb_valid, o_sb_msg, o_sb_src, o_tx_done, o_rx_done, o_arb_busy, o_timeout};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (valid,msg,src,txd,rxd,abusy,tmo)", name, got, exp);
        end
    endtask

    // Reference model: transaction phases of one message exchange
    localparam int PH_WAIT = 0, PH_OFFER = 1, PH_XMIT = 2, PH_FINISH = 3;
    int         m_ph;
    logic       m_last;
    logic       m_mask_on;
    logic       m_mask_src;
    logic       m_src;
    logic [3:0] m_msg;

    task automatic model_reset();
        m_ph = PH_WAIT; m_last = 1'b1; m_mask_on = 1'b0; m_mask_src = 1'b0;
        m_src = 1'b0; m_msg = 4'd0;
    endtask

    // Advance one clock using the inputs the DUT just sampled; return expected outputs.
    task automatic model_step(output logic [9:0] e);
        logic etx, erx, w;
        case (m_ph)
            PH_WAIT: begin
                etx = tx_valid && !(m_mask_on && !m_mask_src);
                erx = rx_valid && !(m_mask_on && m_mask_src);
                m_mask_on = 1'b0;
                if (etx || erx) begin
                    w     = (etx && erx) ? !m_last : erx;
                    m_src = w;
                    m_msg = w ? rx_msg : tx_msg;
                    m_ph  = PH_OFFER;
                end
            end
            PH_OFFER: begin
                if (sb_busy) m_ph = PH_XMIT;
                else if (!(m_src ? rx_valid : tx_valid)) m_ph = PH_WAIT;
            end
            PH_XMIT: if (!sb_busy) m_ph = PH_FINISH;
            default: begin
                m_last = m_src; m_mask_on = 1'b1; m_mask_src = m_src; m_ph = PH_WAIT;
            end
        endcase
        e = {m_ph == PH_OFFER, m_msg, m_src, (m_ph == PH_FINISH) && !m_src,
             (m_ph == PH_FINISH) && m_src, m_ph != PH_WAIT, 1'b0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        logic [9:0] e;
        int tx_gap, rx_gap, enc_ph, enc_cnt;

        rst_n = 1'b0; tx_valid = 1'b0; tx_msg = 4'd0; rx_valid = 1'b0; rx_msg = 4'd0; sb_busy = 1'b0;

        //            rst txv txm rxv rxm bsy | ev em es td rd ab
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        // TX only, busy one cycle, two cycles after valid
        vecs.push_back(mk(1, 1, 3, 0, 0, 0,   1, 3, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 3, 0, 0, 0,   1, 3, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 3, 0, 0, 0,   1, 3, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 3, 0, 0, 1,   0, 3, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 3, 0, 0, 0,   0, 3, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 3, 0, 0, 0,   0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0));
        // Tie from reset: TX first, then RX
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 2, 0,   1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 2, 1,   0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 2, 0,   0, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 2, 0,   0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 2, 0,   1, 2, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 2, 1,   0, 2, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 2, 0,   0, 2, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 2, 1, 0, 0, 0));
        // Late valid drop after TX done must not regrant
        vecs.push_back(mk(1, 1, 5, 0, 0, 0,   1, 5, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 5, 0, 0, 1,   0, 5, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 5, 0, 0, 0,   0, 5, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 5, 0, 0, 0,   0, 5, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 5, 0, 0, 0,   0, 5, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 5, 0, 0, 0, 0));
        // TX withdraws in GRANT; pending RX granted next
        vecs.push_back(mk(1, 1, 6, 0, 0, 0,   1, 6, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 7, 0,   0, 6, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 7, 0,   1, 7, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 7, 1,   0, 7, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 7, 0,   0, 7, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 7, 1, 0, 0, 0));
        // Reset mid-SEND, then tie goes to TX
        vecs.push_back(mk(1, 1, 9, 0, 0, 0,   1, 9, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 9, 0, 0, 1,   0, 9, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 9, 0, 0, 1,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 4, 1, 8, 0,   1, 4, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 4, 1, 8, 1,   0, 4, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 4, 1, 8, 0,   0, 4, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 8, 0,   0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 8, 0,   1, 8, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 8, 1,   0, 8, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 8, 0,   0, 8, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 8, 1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n    = vecs[i].rst_n;
            tx_valid = vecs[i].txv;
            tx_msg   = vecs[i].txm;
            rx_valid = vecs[i].rxv;
            rx_msg   = vecs[i].rxm;
            sb_busy  = vecs[i].busy;
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Randomized requesters and encoder against the reference model
        rst_n = 1'b0; tx_valid = 1'b0; rx_valid = 1'b0; sb_busy = 1'b0;
        tick();
        check("rand_reset", 10'd0);
        rst_n = 1'b1;
        model_reset();
        tx_gap = 0; rx_gap = 0; enc_ph = 0; enc_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            model_step(e);
            check($sformatf("rand_c%0d", c), e);

            if (o_tx_done) begin
                tx_valid = 1'b0; tx_gap = $urandom_range(0, 2);
            end else if (!tx_valid) begin
                if (tx_gap == 0) begin tx_valid = 1'b1; tx_msg = 4'($urandom); end
                else tx_gap--;
            end else if (!(o_arb_busy && !o_sb_src) && $urandom_range(0, 3) == 0) begin
                tx_msg = 4'($urandom);
            end

            if (o_rx_done) begin
                rx_valid = 1'b0; rx_gap = $urandom_range(0, 2);
            end else if (!rx_valid) begin
                if (rx_gap == 0) begin rx_valid = 1'b1; rx_msg = 4'($urandom); end
                else rx_gap--;
            end else if (!(o_arb_busy && o_sb_src) && $urandom_range(0, 3) == 0) begin
                rx_msg = 4'($urandom);
            end

            // Encoder: accept after 0..2 cycles, stay busy 1..3 cycles
            case (enc_ph)
                0: if (o_sb_valid) begin
                    enc_cnt = $urandom_range(0, 2);
                    if (enc_cnt == 0) begin
                        sb_busy = 1'b1; enc_cnt = $urandom_range(1, 3); enc_ph = 2;
                    end else enc_ph = 1;
                end
                1: begin
                    enc_cnt--;
                    if (enc_cnt == 0) begin
                        sb_busy = 1'b1; enc_cnt = $urandom_range(1, 3); enc_ph = 2;
                    end
                end
                default: begin
                    enc_cnt--;
                    if (enc_cnt == 0) begin sb_busy = 1'b0; enc_ph = 0; end
                end
            endcase
        end

`ifdef SB_ARB_TIMEOUT_EN
        // Encoder never accepts: timeout after 8 GRANT cycles, then RX wins
        rst_n = 1'b0; tx_valid = 1'b0; rx_valid = 1'b0; sb_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tx_valid = 1'b1; tx_msg = 4'd3; rx_valid = 1'b1; rx_msg = 4'd5;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("tmo_grant%0d", i), {1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        tick();
        check("tmo_pulse", {1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        tick();
        check("tmo_rx_next", {1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
